// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline controller.
//   - pc_state_e   : 3-bit FSM state encoding
//   - DRAIN_CYCLES : pipeline cycles needed to retire EX, MEM and WB after a HALT
//   - ctrl_t       : bundle of per-cycle stage control strobes
//   - hazard_ctrl(): strobe pattern for an enabled, non-draining pipeline cycle
package pipeline_controller_pkg;

  localparam logic [2:0] StIdleEnc   = 3'd0;
  localparam logic [2:0] StRunEnc    = 3'd1;
  localparam logic [2:0] StStepEnc   = 3'd2;
  localparam logic [2:0] StDrainEnc  = 3'd3;
  localparam logic [2:0] StHaltedEnc = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = StIdleEnc,
    StRun    = StRunEnc,
    StStep   = StStepEnc,
    StDrain  = StDrainEnc,
    StHalted = StHaltedEnc
  } pc_state_e;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned DrainCntW    = 2;

  typedef struct packed {
    logic pc_write;
    logic write_if_id;
    logic flush_if_id;
    logic bubble_id_ex;
    logic pipe_en;
    logic step_done;
  } ctrl_t;

  // Load-use stall outranks a taken branch; the branch is seen again once the
  // stall clears because IF/ID is held.
  function automatic ctrl_t hazard_ctrl(input logic load_use, input logic branch_taken);
    ctrl_t c;
    c         = '0;
    c.pipe_en = 1'b1;
    if (load_use) begin
      c.bubble_id_ex = 1'b1;
    end else begin
      c.pc_write    = 1'b1;
      c.write_if_id = 1'b1;
      c.flush_if_id = branch_taken;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_cycle_counter.sv
// 32-bit executed-cycle counter.
//   clk_i   : clock
//   clr_ni  : synchronous active-low clear
//   en_i    : count enable, +1 per enabled cycle, wraps at 2^32
//   count_o : current count
module pipe_cycle_counter (
  input  logic        clk_i,
  input  logic        clr_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline run/step/halt controller with hazard-driven stage strobes.
// Optional feature macro: PIPE_CYCLE_COUNTER_EN (enables o_cycle_count; tied to 0 otherwise).
// Ports:
//   clk, i_reset_n           : clock, synchronous active-low reset
//   i_run, i_step            : start continuous run / single step from IDLE
//   i_load_use               : load-use hazard in decode (stall)
//   i_branch_taken           : taken branch/jump in decode (flush IF/ID)
//   i_halt_id                : HALT in decode (drain then halt)
//   o_pc_write, o_write_IF_ID, o_flush_IF_ID, o_bubble_ID_EX, o_pipe_en : stage controls
//   o_halted                 : registered, high while in HALTED
//   o_step_done              : high during the single STEP cycle
//   o_cycle_count            : registered count of enabled cycles
module pipeline_controller
  import pipeline_controller_pkg::*;
(
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic        i_run,
  input  logic        i_step,
  input  logic        i_load_use,
  input  logic        i_branch_taken,
  input  logic        i_halt_id,
  output logic        o_pc_write,
  output logic        o_write_IF_ID,
  output logic        o_flush_IF_ID,
  output logic        o_bubble_ID_EX,
  output logic        o_pipe_en,
  output logic        o_halted,
  output logic        o_step_done,
  output logic [31:0] o_cycle_count
);

  pc_state_e             state_d, state_q;
  logic [DrainCntW-1:0]  drain_cnt_d, drain_cnt_q;
  logic                  halted_d, halted_q;
  ctrl_t                 ctrl;
  logic                  halt_go;

  // A HALT seen alongside a load-use stall waits until the stall clears.
  assign halt_go = i_halt_id && !i_load_use;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    ctrl        = '0;
    unique case (state_q)
      StIdle: begin
        if (i_run) begin
          state_d = StRun;
        end else if (i_step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        ctrl = hazard_ctrl(i_load_use, i_branch_taken);
        if (halt_go) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StStep: begin
        ctrl           = hazard_ctrl(i_load_use, i_branch_taken);
        ctrl.step_done = 1'b1;
        if (halt_go) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // Fetch/decode frozen; older instructions retire through EX, MEM, WB.
        ctrl.pipe_en      = 1'b1;
        ctrl.bubble_id_ex = 1'b1;
        if (drain_cnt_q == DrainCntW'(DRAIN_CYCLES - 1)) begin
          state_d     = StHalted;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d     = StIdle;
        drain_cnt_d = '0;
      end
    endcase
    // Strobes stay quiet while reset is held, whatever the current state.
    if (!i_reset_n) begin
      ctrl = '0;
    end
  end

  assign halted_d = (state_d == StHalted);

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign o_pc_write     = ctrl.pc_write;
  assign o_write_IF_ID  = ctrl.write_if_id;
  assign o_flush_IF_ID  = ctrl.flush_if_id;
  assign o_bubble_ID_EX = ctrl.bubble_id_ex;
  assign o_pipe_en      = ctrl.pipe_en;
  assign o_step_done    = ctrl.step_done;
  assign o_halted       = halted_q;

`ifdef PIPE_CYCLE_COUNTER_EN
  pipe_cycle_counter u_cycle_counter (
    .clk_i   (clk),
    .clr_ni  (i_reset_n),
    .en_i    (ctrl.pipe_en),
    .count_o (o_cycle_count)
  );
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller. Inputs change 1 time unit after a
// rising edge; combinational strobes are sampled on the falling edge.
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        i_reset_n, i_run, i_step, i_load_use, i_branch_taken, i_halt_id;
  logic        o_pc_write, o_write_IF_ID, o_flush_IF_ID, o_bubble_ID_EX, o_pipe_en;
  logic        o_halted, o_step_done;
  logic [31:0] o_cycle_count;
  logic [5:0]  strobes;

  int checks = 0;
  int errors = 0;

`ifdef PIPE_CYCLE_COUNTER_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  // {pc_write, write_IF_ID, flush_IF_ID, bubble_ID_EX, pipe_en, step_done}
  localparam logic [5:0] SOff   = 6'b000000;
  localparam logic [5:0] SNorm  = 6'b110010;
  localparam logic [5:0] SStall = 6'b000110;
  localparam logic [5:0] SFlush = 6'b111010;
  localparam logic [5:0] SDrain = 6'b000110;
  localparam logic [5:0] SStep  = 6'b110011;

  always #5 clk = ~clk;

  assign strobes = {o_pc_write, o_write_IF_ID, o_flush_IF_ID, o_bubble_ID_EX, o_pipe_en,
                    o_step_done};

  pipeline_controller dut (
    .clk            (clk),
    .i_reset_n      (i_reset_n),
    .i_run          (i_run),
    .i_step         (i_step),
    .i_load_use     (i_load_use),
    .i_branch_taken (i_branch_taken),
    .i_halt_id      (i_halt_id),
    .o_pc_write     (o_pc_write),
    .o_write_IF_ID  (o_write_IF_ID),
    .o_flush_IF_ID  (o_flush_IF_ID),
    .o_bubble_ID_EX (o_bubble_ID_EX),
    .o_pipe_en      (o_pipe_en),
    .o_halted       (o_halted),
    .o_step_done    (o_step_done),
    .o_cycle_count  (o_cycle_count)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_run = 1'b1; i_step = 1'b1;
    i_load_use = 1'b0; i_branch_taken = 1'b0; i_halt_id = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (strobes !== SOff) begin
      errors++; $display("FAIL reset_strobes got %b want %b", strobes, SOff);
    end
    next_cycle();
    checks++;
    if (o_halted !== 1'b0) begin
      errors++; $display("FAIL reset_halted got %b want 0", o_halted);
    end
    checks++;
    if (o_cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", o_cycle_count);
    end
    i_reset_n = 1'b1; i_run = 1'b0; i_step = 1'b0;
  endtask

  task automatic test_run();
    logic [31:0] exp_cnt;
    i_run = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes !== SOff) begin
      errors++; $display("FAIL idle_strobes got %b want %b", strobes, SOff);
    end
    next_cycle();
    i_run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (strobes !== SNorm) begin
        errors++; $display("FAIL run_norm cyc%0d got %b want %b", i, strobes, SNorm);
      end
      next_cycle();
    end
    exp_cnt = CntEn ? 32'd10 : 32'd0;
    checks++;
    if (o_cycle_count !== exp_cnt) begin
      errors++; $display("FAIL run_count got %0d want %0d", o_cycle_count, exp_cnt);
    end
  endtask

  task automatic test_load_use();
    i_load_use = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes !== SStall) begin
      errors++; $display("FAIL lu_stall got %b want %b", strobes, SStall);
    end
    next_cycle();
    i_load_use = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== SNorm) begin
      errors++; $display("FAIL lu_after got %b want %b", strobes, SNorm);
    end
    next_cycle();
  endtask

  task automatic test_lu_branch();
    i_load_use = 1'b1; i_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes !== SStall) begin
      errors++; $display("FAIL lubr_stall got %b want %b", strobes, SStall);
    end
    next_cycle();
    i_load_use = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== SFlush) begin
      errors++; $display("FAIL lubr_flush got %b want %b", strobes, SFlush);
    end
    next_cycle();
    i_branch_taken = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== SNorm) begin
      errors++; $display("FAIL lubr_after got %b want %b", strobes, SNorm);
    end
    next_cycle();
  endtask

  // Halt deferred by a stall, then drain and halt; run/step ignored once halted.
  task automatic test_halt_drain();
    logic [31:0] exp_cnt;
    i_halt_id = 1'b1; i_load_use = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes !== SStall) begin
      errors++; $display("FAIL halt_lu_stall got %b want %b", strobes, SStall);
    end
    next_cycle();
    i_load_use = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== SNorm) begin
      errors++; $display("FAIL halt_deferred got %b want %b", strobes, SNorm);
    end
    next_cycle();
    i_halt_id = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_branch_taken = (i == 1);
      @(negedge clk);
      checks++;
      if (strobes !== SDrain || o_halted !== 1'b0) begin
        errors++;
        $display("FAIL drain cyc%0d got %b/%b want %b/0", i, strobes, o_halted, SDrain);
      end
      next_cycle();
    end
    i_branch_taken = 1'b0;
    checks++;
    if (o_halted !== 1'b1) begin
      errors++; $display("FAIL halted_set got %b want 1", o_halted);
    end
    exp_cnt = CntEn ? 32'd20 : 32'd0;
    checks++;
    if (o_cycle_count !== exp_cnt) begin
      errors++; $display("FAIL halt_count got %0d want %0d", o_cycle_count, exp_cnt);
    end
    i_run = 1'b1; i_step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (strobes !== SOff || o_halted !== 1'b1) begin
        errors++;
        $display("FAIL halted_hold cyc%0d got %b/%b want %b/1", i, strobes, o_halted, SOff);
      end
      next_cycle();
    end
    i_run = 1'b0; i_step = 1'b0;
    checks++;
    if (o_cycle_count !== exp_cnt) begin
      errors++; $display("FAIL halted_count got %0d want %0d", o_cycle_count, exp_cnt);
    end
  endtask

  task automatic test_step();
    logic [31:0] exp_cnt;
    i_reset_n = 1'b0;
    next_cycle();
    i_reset_n = 1'b1;
    checks++;
    if (o_halted !== 1'b0) begin
      errors++; $display("FAIL step_rst_halted got %b want 0", o_halted);
    end
    for (int i = 0; i < 3; i++) begin
      i_step = 1'b1;
      @(negedge clk);
      checks++;
      if (strobes !== SOff) begin
        errors++; $display("FAIL step_idle%0d got %b want %b", i, strobes, SOff);
      end
      next_cycle();
      i_step = 1'b0;
      @(negedge clk);
      checks++;
      if (strobes !== SStep) begin
        errors++; $display("FAIL step_pulse%0d got %b want %b", i, strobes, SStep);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (strobes !== SOff) begin
        errors++; $display("FAIL step_back%0d got %b want %b", i, strobes, SOff);
      end
      next_cycle();
    end
    exp_cnt = CntEn ? 32'd3 : 32'd0;
    checks++;
    if (o_cycle_count !== exp_cnt) begin
      errors++; $display("FAIL step_count got %0d want %0d", o_cycle_count, exp_cnt);
    end
  endtask

  // Step with HALT enters DRAIN; reset in the second drain cycle returns to IDLE.
  task automatic test_reset_mid_drain();
    i_step = 1'b1;
    next_cycle();
    i_step = 1'b0; i_halt_id = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes !== SStep) begin
      errors++; $display("FAIL stephalt_pulse got %b want %b", strobes, SStep);
    end
    next_cycle();
    i_halt_id = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== SDrain) begin
      errors++; $display("FAIL stephalt_drain got %b want %b", strobes, SDrain);
    end
    next_cycle();
    i_reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (strobes !== SOff) begin
      errors++; $display("FAIL drain_rst_strobes got %b want %b", strobes, SOff);
    end
    next_cycle();
    i_reset_n = 1'b1;
    checks++;
    if (o_halted !== 1'b0 || o_cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL drain_rst_state got %b/%0d want 0/0", o_halted, o_cycle_count);
    end
    @(negedge clk);
    checks++;
    if (strobes !== SOff) begin
      errors++; $display("FAIL drain_rst_idle got %b want %b", strobes, SOff);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (o_halted !== 1'b0) begin
      errors++; $display("FAIL drain_rst_nohalt got %b want 0", o_halted);
    end
  endtask

  // Run and step together must behave as run: enabled on consecutive cycles.
  task automatic test_run_and_step();
    i_run = 1'b1; i_step = 1'b1;
    next_cycle();
    i_run = 1'b0; i_step = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (strobes !== SNorm) begin
        errors++; $display("FAIL runstep cyc%0d got %b want %b", i, strobes, SNorm);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_use();
    test_lu_branch();
    test_halt_drain();
    test_step();
    test_reset_mid_drain();
    test_run_and_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have port: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: i_reset_n  in  1  synchronous, active-low reset; one clock, no other clock domain.
REQ-003 SHALL have port: i_run  in  1  pulse: start continuous execution from IDLE.
REQ-004 SHALL have port: i_step  in  1  pulse: execute exactly one clock of pipeline advance from IDLE.
REQ-005 SHALL have port: i_load_use  in  1  decode load-use hazard (ID_EX MemRead and rt matches rs/rt).
REQ-006 SHALL have port: i_branch_taken  in  1  branch/jump resolved taken in decode.
REQ-007 SHALL have port: i_halt_id  in  1  HALT opcode present in decode.
REQ-008 SHALL have ports: o_pc_write, o_write_IF_ID, o_flush_IF_ID, o_bubble_ID_EX, o_pipe_en  out  1 each  stage write/flush/enable controls.
REQ-009 SHALL have ports: o_halted, o_step_done  out  1 each  status; o_cycle_count  out  32  executed-cycle count.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, STEP, DRAIN, HALTED.
REQ-011 IDLE: o_pipe_en=0; i_run -> RUN; i_step -> STEP; i_run and i_step together -> RUN.
REQ-012 STEP: o_pipe_en=1 for exactly one cycle, o_step_done=1 in that same cycle, then -> IDLE (or DRAIN if i_halt_id that cycle).
REQ-013 RUN: o_pipe_en=1 every cycle until i_halt_id=1, then -> DRAIN next cycle.
REQ-014 DRAIN: o_pc_write=0, o_write_IF_ID=0, o_bubble_ID_EX=1, o_pipe_en=1 for exactly 3 cycles (EX, MEM, WB retire), counted by a 2-bit counter, then -> HALTED.
REQ-015 HALTED: o_halted=1, o_pipe_en=0, all write strobes 0; leaves only on reset; i_run/i_step ignored.
REQ-016 When o_pipe_en=0 all other strobes SHALL be 0 and stage inputs ignored.
REQ-017 When o_pipe_en=1 and i_load_use=1: o_pc_write=0, o_write_IF_ID=0, o_bubble_ID_EX=1, o_flush_IF_ID=0 (one-cycle stall).
REQ-018 When o_pipe_en=1, i_branch_taken=1, i_load_use=0: o_pc_write=1, o_write_IF_ID=1, o_flush_IF_ID=1.
REQ-019 Simultaneous i_load_use and i_branch_taken: stall wins, flush suppressed; branch re-evaluated next enabled cycle.
REQ-020 Simultaneous i_halt_id and i_load_use: stall applies this cycle, halt transition deferred until i_halt_id seen with i_load_use=0.
REQ-021 Otherwise with o_pipe_en=1: o_pc_write=1, o_write_IF_ID=1, flush/bubble 0.
REQ-022 All outputs SHALL be combinational from state and inputs except o_halted, o_cycle_count (registered).

Reset
REQ-023 i_reset_n=0 at a clock edge SHALL force IDLE, drain counter 0, o_cycle_count 0, o_halted 0, from any state including mid-DRAIN or mid-STEP.
REQ-024 During reset all write strobes, o_pipe_en, o_step_done SHALL be 0.

Configuration
REQ-025 Macro PIPE_CYCLE_COUNTER_EN defined: o_cycle_count increments by 1 every cycle with o_pipe_en=1, wraps 0xFFFFFFFF -> 0.
REQ-026 Macro undefined: o_cycle_count tied to 0, no counter flops.

Structure
REQ-027 Shared package SHALL hold the state encoding (3-bit localparams) and DRAIN_CYCLES=3.
REQ-028 Counter under PIPE_CYCLE_COUNTER_EN SHALL be sub-module pipe_cycle_counter (enable, sync active-low clear, 32-bit out).

Verification
REQ-029 Reset, pulse i_run, no hazards 10 cycles -> o_pc_write=1 each cycle, o_cycle_count=10.
REQ-030 In RUN assert i_load_use one cycle -> that cycle o_pc_write=0, o_write_IF_ID=0, o_bubble_ID_EX=1; next cycle normal.
REQ-031 i_load_use=1 and i_branch_taken=1 same cycle -> o_flush_IF_ID=0, stall; next cycle branch only -> o_flush_IF_ID=1.
REQ-032 i_halt_id=1 in RUN -> 3 DRAIN cycles with o_bubble_ID_EX=1, then o_halted=1, o_pipe_en=0; i_run ignored.
REQ-033 From IDLE pulse i_step 3 times -> three single o_pipe_en/o_step_done pulses, o_cycle_count=3.
REQ-034 i_reset_n=0 during 2nd DRAIN cycle -> next cycle IDLE, o_halted=0, o_cycle_count=0.
